tc_display_driver: RTL and testbench
====================================

# tc_display_driver

Sequential two's-complement-to-7-segment driver for a multi-digit display. It generalises the 4-bit single-digit converter to a parametrised WIDTH-bit signed input shown across DIGITS decimal digits plus a dedicated sign display. Conversion is a multi-cycle shift-add-3 (double-dabble) sequence launched by a load handshake. Outputs are registered, active-low, and hold the last result between conversions. The block sits between datapath result registers and the board HEX displays.

## Interface
- WIDTH, 8: input width in bits, two's complement; legal range 2..16
- DIGITS, 3: number of magnitude digit displays; elaboration error if DIGITS < decimal digit count of 2^(WIDTH-1)
- BLANK_ZEROS, 1: 1 blanks leading zero digits; digit 0 is never blanked
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  request to convert `value`; accepted only when busy=0
- value  in  WIDTH  two's-complement number, sampled on the accepting edge
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new segment outputs become valid
- sign_seg  out  7  sign display, active low, bit 6 = segment g
- mag_seg  out  7*DIGITS  digit displays, active low; bits [7i+6:7i] drive decimal digit i (i=0 is units)

## Operation
- Segment map (active low, bit n = segment n, 0=top, 1=top-right, 2=bottom-right, 3=bottom, 4=bottom-left, 5=top-left, 6=middle):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111; minus=0111111 (middle segment only)
- FSM states:
  - IDLE: load=1 captures sign=value[WIDTH-1] and magnitude=|value| as a WIDTH-bit unsigned number. -2^(WIDTH-1) yields 2^(WIDTH-1) with no saturation. The BCD accumulator is cleared, the shift counter is set to WIDTH, and the FSM moves to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift the magnitude MSB into the BCD LSB and decrement the counter. When the counter reaches 0, register the segment outputs, pulse done, and return to IDLE.
- Sign display shows minus when the captured sign=1, else blank. Zero is never negative.
- Blanking (BLANK_ZEROS=1): digit i>0 is blank if it and all higher digits are 0.
- load while busy=1 is ignored. No queueing; value is not re-sampled.
- Outputs change only at the completion edge. Between conversions they hold the last result.

## Timing
- Reset values: sign_seg=1111111, all mag_seg digits=1111111, busy=0, done=0. FSM goes to IDLE, counter=0.
- Load accepted at edge k:
  - busy=1 from after edge k.
  - WIDTH shift edges k+1..k+WIDTH.
  - At edge k+WIDTH: segment outputs update, done=1 for exactly one cycle, busy=0.
- Latency is WIDTH cycles from the accepting edge to valid outputs.
- Back-to-back: load=1 during the done cycle is accepted (FSM is IDLE). Throughput is one result per WIDTH+1 cycles.
- Reset mid-conversion: abort, restore all reset values next edge. No done pulse for the aborted conversion.
- Reset has priority over load on the same edge.

## Structure
- Package seg7_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_MINUS
  - FSM state enum (IDLE, CONVERT)
  - function computing the required digit count from WIDTH, for the elaboration check
- Sub-module bcd_to_7seg: combinational 4-bit BCD to 7-segment with a blank input. Instantiated DIGITS times. Codes 10..15 map to blank.
- Top holds the FSM, shift counter, magnitude/BCD shift register, and output registers.

## Test plan
- Reset (WIDTH=8, DIGITS=3) -> sign_seg=1111111, all digits 1111111, busy=0, done=0.
- load value=8'h7F -> done exactly 8 cycles after acceptance; sign 1111111, digits (hundreds..units) 1111001, 0100100, 1111000.
- load value=8'h80 -> sign 0111111, digits 1111001, 0100100, 0000000 (−128).
- load 8'hFB:
  - BLANK_ZEROS=1 -> sign 0111111, digits 1111111, 1111111, 0010010
  - BLANK_ZEROS=0 -> digits 1000000, 1000000, 0010010
- load 8'h00 -> sign 1111111, units 1000000, upper digits blank.
- load 8'h05 then load 8'h7F two cycles later -> second load ignored, result shows 5.
- Separately: reset at cycle 4 of a conversion -> reset values, no done pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment codes, converter FSM states and the digit-count helper used for elaboration checks
package seg7_pkg;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  typedef enum logic {IDLE, CONVERT} state_e;
  function automatic int digits_needed(input int width);
    int v = 1 << (width - 1);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/tc_display_driver_if.sv
// tc_display_driver_if: load/value request in, busy/done status and active-low sign_seg/mag_seg displays out
interface tc_display_driver_if #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [6:0]            sign_seg;
  logic [7*DIGITS-1:0]   mag_seg;
  modport master (output load, value, input busy, done, sign_seg, mag_seg);
  modport slave  (input load, value, output busy, done, sign_seg, mag_seg);
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: bcd_i nibble plus blank_i to active-low seg_o; codes 10..15 and blank_i show blank
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = (blank_i || bcd_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd_i];
endmodule

// File: rtl/tc_display_driver.sv
// tc_display_driver: signed WIDTH-bit value to sign + DIGITS 7-segment displays via multi-cycle double-dabble; clk, reset, bus (slave)
module tc_display_driver
  import seg7_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input logic                clk,
  input logic                reset,
  tc_display_driver_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  if (WIDTH < 2 || WIDTH > 16 || DIGITS < digits_needed(WIDTH)) begin : g_bad_params
    $error("tc_display_driver: illegal WIDTH/DIGITS combination");
  end
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [BW-1:0]       bcd_q, bcd_d, adj, bcd_sh;
  logic [WIDTH-1:0]    mag_sh;
  logic                sign_q, sign_d, done_q, done_d;
  logic [6:0]          sign_seg_q, sign_seg_d;
  logic [7*DIGITS-1:0] mag_seg_q, mag_seg_d, seg;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  assign {bcd_sh, mag_sh} = {adj, mag_q} << 1;
  // Decoders see the post-shift BCD so the final shift and the output capture share one edge.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_to_7seg u_dec (
      .bcd_i   (bcd_sh[4*i+:4]),
      .blank_i (BLANK_ZEROS && i != 0 && (bcd_sh >> (4 * i)) == '0),
      .seg_o   (seg[7*i+:7])
    );
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    done_d     = 1'b0;
    sign_seg_d = sign_seg_q;
    mag_seg_d  = mag_seg_q;
    if (state_q == IDLE) begin
      if (bus.load) begin
        sign_d  = bus.value[WIDTH-1];
        mag_d   = bus.value[WIDTH-1] ? -bus.value : bus.value;
        bcd_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = CONVERT;
      end
    end else begin
      bcd_d = bcd_sh;
      mag_d = mag_sh;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d    = IDLE;
        done_d     = 1'b1;
        sign_seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
        mag_seg_d  = seg;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_seg_q <= SEG_BLANK;
      mag_seg_q  <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
      sign_seg_q <= sign_seg_d;
      mag_seg_q  <= mag_seg_d;
    end
  end
  assign bus.busy     = state_q == CONVERT;
  assign bus.done     = done_q;
  assign bus.sign_seg = sign_seg_q;
  assign bus.mag_seg  = mag_seg_q;
endmodule

// File: tb/tb_tc_display_driver.sv
// tb_tc_display_driver: directed table plus corner sequences for tc_display_driver with and without zero blanking
module tb_tc_display_driver;
  localparam int W = 8, D = 3;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S4 = 7'h19, S5 = 7'h12,
                         S7 = 7'h78, S8 = 7'h00, BL = 7'h7F, MI = 7'h3F;
  typedef struct {
    logic [W-1:0]     v;
    logic [6:0]       sgn;
    logic [7*D-1:0]   mag_bz;
    logic [7*D-1:0]   mag_nb;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [W-1:0] value = '0;
  int checks = 0, failures = 0;
  tc_display_driver_if #(.WIDTH(W), .DIGITS(D)) b0 ();
  tc_display_driver_if #(.WIDTH(W), .DIGITS(D)) b1 ();
  assign b0.load = load;
  assign b0.value = value;
  assign b1.load = load;
  assign b1.value = value;
  tc_display_driver #(.WIDTH(W), .DIGITS(D), .BLANK_ZEROS(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  tc_display_driver #(.WIDTH(W), .DIGITS(D), .BLANK_ZEROS(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [W-1:0] v);
    load = 1'b1;
    value = v;
    step();
    load = 1'b0;
    value = 8'h33;
    chk("busy_after_accept", 32'(b0.busy), 32'd1);
  endtask
  task automatic wait_done(input int already, input string name);
    int n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (b0.done) begin
        n = i;
        break;
      end
    end
    chk({name, "_latency"}, n + already, W);
    chk({name, "_busy_at_done"}, 32'(b0.busy), 32'd0);
    chk({name, "_done_nb"}, 32'(b1.done), 32'd1);
  endtask
  task automatic chk_out(input string name, input logic [6:0] sgn, input logic [7*D-1:0] bz, input logic [7*D-1:0] nb);
    chk({name, "_sign"}, 32'(b0.sign_seg), 32'(sgn));
    chk({name, "_mag"}, 32'(b0.mag_seg), 32'(bz));
    chk({name, "_sign_nb"}, 32'(b1.sign_seg), 32'(sgn));
    chk({name, "_mag_nb"}, 32'(b1.mag_seg), 32'(nb));
  endtask
  initial begin
    vec_t tbl[7];
    bit seen;
    tbl[0] = '{8'h7F, BL, {S1, S2, S7}, {S1, S2, S7}};
    tbl[1] = '{8'h80, MI, {S1, S2, S8}, {S1, S2, S8}};
    tbl[2] = '{8'hFB, MI, {BL, BL, S5}, {S0, S0, S5}};
    tbl[3] = '{8'h00, BL, {BL, BL, S0}, {S0, S0, S0}};
    tbl[4] = '{8'h0A, BL, {BL, S1, S0}, {S0, S1, S0}};
    tbl[5] = '{8'h9C, MI, {S1, S0, S0}, {S1, S0, S0}};
    tbl[6] = '{8'h01, BL, {BL, BL, S1}, {S0, S0, S1}};
    step();
    step();
    chk_out("reset", BL, {3{BL}}, {3{BL}});
    chk("reset_busy", 32'(b0.busy), 32'd0);
    chk("reset_done", 32'(b0.done), 32'd0);
    reset = 1'b0;
    step();
    for (int t = 0; t < 7; t++) begin
      start(tbl[t].v);
      wait_done(0, $sformatf("vec%0d", t));
      chk_out($sformatf("vec%0d", t), tbl[t].sgn, tbl[t].mag_bz, tbl[t].mag_nb);
      step();
      chk($sformatf("vec%0d_done_drop", t), 32'(b0.done), 32'd0);
      chk($sformatf("vec%0d_hold", t), 32'(b0.mag_seg), 32'(tbl[t].mag_bz));
    end
    start(8'h11);
    wait_done(0, "b2b_first");
    chk_out("b2b_first", BL, {BL, S1, S7}, {S0, S1, S7});
    start(8'h2A);
    chk("b2b_done_drop", 32'(b0.done), 32'd0);
    wait_done(0, "b2b_second");
    chk_out("b2b_second", BL, {BL, S4, S2}, {S0, S4, S2});
    step();
    start(8'h05);
    step();
    load = 1'b1;
    value = 8'h7F;
    step();
    load = 1'b0;
    chk("ignore_busy", 32'(b0.busy), 32'd1);
    wait_done(2, "ignore");
    chk_out("ignore", BL, {BL, BL, S5}, {S0, S0, S5});
    step();
    start(8'h7F);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("midreset", BL, {3{BL}}, {3{BL}});
    chk("midreset_busy", 32'(b0.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= b0.done | b1.done;
      step();
    end
    chk("midreset_no_done", 32'(seen), 32'd0);
    chk_out("midreset_hold", BL, {3{BL}}, {3{BL}});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
